// File: rtl/dag2_pkg.sv
// Shared types and golden function for the dag2 logic micro benchmark checker.
package dag2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } dag2_state_e;

  localparam int DAG2_BITS = 2;

  // Evaluated as written so the benchmark's expression is what gets checked;
  // algebraically it reduces to a & ~b.
  function automatic logic [31:0] dag2_ref(input logic [31:0] a, input logic [31:0] b);
    return (a | b) & ((a | b) ^ b);
  endfunction

endpackage

// File: rtl/bm_dag2_log_ref.sv
// Combinational golden model for the dag2 logic benchmark, BITS <= 32.
module bm_dag2_log_ref
  import dag2_pkg::*;
#(
  parameter int BITS = DAG2_BITS
) (
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  output logic [BITS-1:0] y
);

  logic [31:0] y_full;

  assign y_full = dag2_ref(32'(a), 32'(b));
  assign y      = y_full[BITS-1:0];

endmodule

// File: rtl/bm_dag2_log_chk.sv
// Self-check partner for the dag2 micro benchmark: two-stage compare pipeline
// with run sequencing. Optional macro DAG2_CHK_STOP_ON_ERR_EN ends a run early.
//
//  state    | meaning
//  ---------+----------------------------------------------------
//  ST_IDLE  | waiting for start, no vectors accepted
//  ST_RUN   | accepting vectors until NUM_VEC have been taken
//  ST_DRAIN | no accepts, letting the compare pipeline empty
//  ST_DONE  | results stable, done/pass asserted until start
module bm_dag2_log_chk
  import dag2_pkg::*;
#(
  parameter int BITS    = DAG2_BITS,
  parameter int NUM_VEC = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BITS-1:0]  a_in,
  input  logic [BITS-1:0]  b_in,
  input  logic [BITS-1:0]  dut_out,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_idx,
  output logic             done,
  output logic             pass
);

  localparam logic [CNT_W-1:0] NUM_VEC_C = CNT_W'(NUM_VEC);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(NUM_VEC - 1);
  localparam logic [CNT_W-1:0] ERR_MAX   = {CNT_W{1'b1}};

  dag2_state_e state, state_nxt;

  logic [CNT_W-1:0] acc_cnt;
  logic             accept;
  logic             clr_cnt;
  logic             stop_hit;
  logic             count_en;

  logic             s1_valid;
  logic [BITS-1:0]  s1_a;
  logic [BITS-1:0]  s1_b;
  logic [BITS-1:0]  s1_dut;
  logic [CNT_W-1:0] s1_idx;
  logic [BITS-1:0]  s1_ref;
  logic             s1_mis;

  // in_ready deliberately ignores in_valid so upstream can use it freely.
  assign in_ready = (state == ST_RUN) && (acc_cnt < NUM_VEC_C);
  assign accept   = in_valid && in_ready;

  bm_dag2_log_ref #(.BITS(BITS)) u_ref (
    .a (s1_a),
    .b (s1_b),
    .y (s1_ref)
  );

  // Case inequality so an X on the DUT result is flagged in simulation.
  assign s1_mis = (s1_dut !== s1_ref);

`ifdef DAG2_CHK_STOP_ON_ERR_EN
  assign count_en = s1_valid && s1_mis && (err_count == '0);
  assign stop_hit = (state == ST_RUN) && count_en;
`else
  assign count_en = s1_valid && s1_mis;
  assign stop_hit = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    clr_cnt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_RUN;
          clr_cnt   = 1'b1;
        end
      end
      ST_RUN: begin
        if ((accept && (acc_cnt == LAST_IDX)) || stop_hit) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // S2 folds its result into the counters on the edge S1 empties.
        if (!s1_valid) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_nxt = ST_RUN;
          clr_cnt   = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_dut   <= '0;
      s1_idx   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_a   <= a_in;
        s1_b   <= b_in;
        s1_dut <= dut_out;
        s1_idx <= acc_cnt;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_cnt       <= '0;
      err_count     <= '0;
      first_err_idx <= '0;
    end else if (clr_cnt) begin
      acc_cnt       <= '0;
      err_count     <= '0;
      first_err_idx <= '0;
    end else begin
      if (accept) begin
        acc_cnt <= acc_cnt + 1'b1;
      end
      if (count_en) begin
        if (err_count != ERR_MAX) begin
          err_count <= err_count + 1'b1;
        end
        if (err_count == '0) begin
          first_err_idx <= s1_idx;
        end
      end
    end
  end

  assign done = (state == ST_DONE);
  assign pass = done && (err_count == '0);

endmodule
